// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port (if_*) and the load/store data port (d_*). Only one transaction is
//   in flight at a time. Each transaction passes through four states:
//   IDLE (select owner), ISSUE (mem_req + gnt), WAIT (response or watchdog)
//   and RESP (rvalid/err to the owner). The fastest possible round trip is
//   therefore 4 cycles.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   - on contention, the port that was not granted last wins
//                 (the last-owner register resets to fetch).
//     undefined - the data port wins on contention. The exception is a
//                 fetch that has waited through STARVE_MAX data grants in
//                 a row; that fetch wins instead.
//
//   Ports
//     clk, rst_n       clock, synchronous active-low reset
//     if_req/if_addr   fetch request and word address (held until if_gnt)
//     if_gnt           fetch accepted (1-cycle pulse)
//     if_rvalid/rdata  fetch response (1-cycle pulse)
//     d_req/we/be/addr/wdata  data request (held until d_gnt)
//     d_gnt            data accepted (1-cycle pulse)
//     d_rvalid/rdata   data response; rdata is 0 for stores
//     err              watchdog abort, pulses together with the rvalid
//     mem_req          issue strobe to memory
//     mem_we/be/addr/wdata  command, stable from issue to completion
//     mem_rvalid/rdata memory completion and read data
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDRSIZE   = 12,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDRSIZE-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [WIDTH-1:0]    if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [3:0]          d_be,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic [WIDTH-1:0]    d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WIDTH-1:0]    d_rdata,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [3:0]          mem_be,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic                mem_rvalid,
    input  logic [WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_reg, state_next;
    logic                  owner_data_reg;   // 1: data port owns the transaction
    logic                  mem_we_reg;
    logic [3:0]            mem_be_reg;
    logic [ADDRSIZE-1:0]   mem_addr_reg;
    logic [WIDTH-1:0]      mem_wdata_reg;
    logic [WIDTH-1:0]      rdata_reg;
    logic                  err_reg;
    logic [7:0]            wdog_reg;
    logic                  wdog_hit;
    logic                  pick_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_data_reg;    // 1: previous grant went to data

    always_comb begin
        pick_data = d_req && (!if_req || !last_data_reg);
    end
`else
    logic [3:0]            starve_reg;       // data grants given while fetch waited

    always_comb begin
        pick_data = d_req && (!if_req || (starve_reg != 4'(STARVE_MAX)));
    end
`endif

    // Abort on the last WAIT cycle. A mem_rvalid on that same edge still wins,
    // because the WAIT branch checks mem_rvalid first.
    assign wdog_hit = (wdog_reg == 8'(TIMEOUT));

    assign mem_we    = mem_we_reg;
    assign mem_be    = mem_be_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        err        = 1'b0;
        if_rdata   = '0;
        d_rdata    = '0;
        case (state_reg)
            IDLE: begin
                if (if_req || d_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req    = 1'b1;
                if_gnt     = !owner_data_reg;
                d_gnt      = owner_data_reg;
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_rvalid || wdog_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if_rvalid = !owner_data_reg;
                d_rvalid  = owner_data_reg;
                err       = err_reg;
                if (owner_data_reg) begin
                    d_rdata = rdata_reg;
                end else begin
                    if_rdata = rdata_reg;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_data_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            wdog_reg       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_reg  <= 1'b0;
`else
            starve_reg     <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_data_reg <= pick_data;
                        if (pick_data) begin
                            mem_we_reg    <= d_we;
                            mem_be_reg    <= d_be;
                            mem_addr_reg  <= d_addr;
                            mem_wdata_reg <= d_wdata;
                        end else begin
                            mem_we_reg    <= 1'b0;
                            mem_be_reg    <= '0;
                            mem_addr_reg  <= if_addr;
                            mem_wdata_reg <= '0;
                        end
                    end
                end
                ISSUE: begin
                    wdog_reg <= '0;
                    err_reg  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_reg <= owner_data_reg;
`else
                    if (!owner_data_reg) begin
                        starve_reg <= '0;
                    end else if (if_req && (starve_reg != 4'hF)) begin
                        starve_reg <= starve_reg + 4'd1;
                    end
`endif
                end
                WAIT: begin
                    wdog_reg <= wdog_reg + 8'd1;
                    if (mem_rvalid) begin
                        // Stores complete with zero data so the LSU sees no stale value.
                        rdata_reg <= mem_we_reg ? '0 : mem_rdata;
                        err_reg   <= 1'b0;
                    end else if (wdog_hit) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized transaction-level check of mem_port_arbiter. The bench keeps
//   a reference model with two pending request slots and the arbitration
//   rule. It plays the memory, choosing a response latency per transaction.
//   For every transaction it checks the IDLE, ISSUE, WAIT and RESP cycles.
//   Set ARB_ROUND_ROBIN_EN identically for the bench and the design.
module tb_mem_port_arbiter;
    localparam int WIDTH      = 32;
    localparam int ADDRSIZE   = 12;
    localparam int TIMEOUT    = 15;
    localparam int STARVE_MAX = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                if_req = 1'b0;
    logic [ADDRSIZE-1:0] if_addr = '0;
    logic                if_gnt, if_rvalid;
    logic [WIDTH-1:0]    if_rdata;
    logic                d_req = 1'b0;
    logic                d_we = 1'b0;
    logic [3:0]          d_be = '0;
    logic [ADDRSIZE-1:0] d_addr = '0;
    logic [WIDTH-1:0]    d_wdata = '0;
    logic                d_gnt, d_rvalid;
    logic [WIDTH-1:0]    d_rdata;
    logic                err, mem_req, mem_we;
    logic [3:0]          mem_be;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic                mem_rvalid = 1'b0;
    logic [WIDTH-1:0]    mem_rdata = '0;

    mem_port_arbiter #(
        .WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn_no = 0;

    // Reference model: pending requests plus arbitration history.
    bit                  f_pend = 1'b0;
    logic [ADDRSIZE-1:0] f_addr_m = '0;
    bit                  d_pend = 1'b0;
    logic                d_we_m = 1'b0;
    logic [3:0]          d_be_m = '0;
    logic [ADDRSIZE-1:0] d_addr_m = '0;
    logic [WIDTH-1:0]    d_wdata_m = '0;
    int                  starve_m = 0;
    bit                  last_data_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_pick_data();
        if (!f_pend) return 1'b1;
        if (!d_pend) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_data_m;
`else
        return starve_m != STARVE_MAX;
`endif
    endfunction

    task automatic drive_reqs();
        if_req  = f_pend;
        if_addr = f_addr_m;
        d_req   = d_pend;
        d_we    = d_we_m;
        d_be    = d_be_m;
        d_addr  = d_addr_m;
        d_wdata = d_wdata_m;
    endtask

    task automatic new_fetch();
        f_pend   = 1'b1;
        f_addr_m = ADDRSIZE'($urandom);
    endtask

    task automatic new_data();
        d_pend    = 1'b1;
        d_we_m    = 1'($urandom_range(0, 1));
        d_be_m    = 4'($urandom);
        d_addr_m  = ADDRSIZE'($urandom);
        d_wdata_m = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, err, mem_req, mem_we}), 64'd0);
        chk({tag, "_rdata"}, 64'({if_rdata, d_rdata}), 64'd0);
        chk({tag, "_cmd"}, 64'({mem_be, mem_addr, mem_wdata}), 64'd0);
    endtask

    // Called #1 after an edge that left the DUT in IDLE. It returns #1 after
    // the edge that ends RESP, when the DUT is back in IDLE.
    // lat = WAIT cycle index at which memory answers; lat < 0 means never.
    task automatic run_txn(input int lat, input bit stray, input logic [WIDTH-1:0] rdat,
                           output bit got_d);
        bit                  win_d, exp_err;
        logic                exp_we;
        logic [3:0]          exp_be;
        logic [ADDRSIZE-1:0] exp_addr;
        logic [WIDTH-1:0]    exp_wdata, exp_rd;
        int                  c;
        drive_reqs();
        mem_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata  = $urandom;
        win_d = model_pick_data();
        @(negedge clk);
        chk("idle_quiet", 64'({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, err}), 64'd0);

        @(posedge clk); #1;
        mem_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        exp_we    = win_d ? d_we_m : 1'b0;
        exp_be    = d_be_m;
        exp_addr  = win_d ? d_addr_m : f_addr_m;
        exp_wdata = d_wdata_m;
        @(negedge clk);
        got_d = d_gnt;
        chk("issue_if_gnt", 64'(if_gnt), 64'(!win_d));
        chk("issue_d_gnt", 64'(d_gnt), 64'(win_d));
        chk("issue_mem_req", 64'(mem_req), 64'd1);
        chk("issue_addr_we", 64'({mem_we, mem_addr}), 64'({exp_we, exp_addr}));
        if (win_d) begin
            chk("issue_be_wdata", 64'({mem_be, mem_wdata}), 64'({exp_be, exp_wdata}));
            if (f_pend && starve_m < 15) starve_m++;
            last_data_m = 1'b1;
        end else begin
            starve_m    = 0;
            last_data_m = 1'b0;
        end

        for (c = 0; c <= TIMEOUT; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if (win_d) d_pend = 1'b0; else f_pend = 1'b0;
                drive_reqs();
            end
            mem_rvalid = (c == lat);
            mem_rdata  = (c == lat) ? rdat : $urandom;
            @(negedge clk);
            chk("wait_quiet", 64'({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, err}), 64'd0);
            chk("wait_hold", 64'({mem_we, mem_addr}), 64'({exp_we, exp_addr}));
            if (c == lat) break;
        end

        exp_err = !(lat >= 0 && lat <= TIMEOUT);
        exp_rd  = (exp_err || exp_we) ? '0 : rdat;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("resp_if_rvalid", 64'(if_rvalid), 64'(!win_d));
        chk("resp_d_rvalid", 64'(d_rvalid), 64'(win_d));
        chk("resp_err", 64'(err), 64'(exp_err));
        chk("resp_if_rdata", 64'(if_rdata), win_d ? 64'd0 : 64'(exp_rd));
        chk("resp_d_rdata", 64'(d_rdata), win_d ? 64'(exp_rd) : 64'd0);
        $display("txn %0d port=%s we=%0d addr=%03h lat=%0d err=%0d rdata=%08h",
                 txn_no, win_d ? "D" : "F", exp_we, exp_addr, lat, exp_err, exp_rd);
        txn_no++;
        @(posedge clk); #1;
    endtask

    task automatic random_txn();
        int  r, lat;
        bit  g;
        if (!f_pend && $urandom_range(0, 1) == 1) new_fetch();
        if (!d_pend && $urandom_range(0, 1) == 1) new_data();
        if (!f_pend && !d_pend) begin
            if ($urandom_range(0, 1) == 1) new_fetch(); else new_data();
        end
        r = int'($urandom_range(0, 9));
        if (r <= 5)      lat = r;
        else if (r == 6) lat = TIMEOUT;
        else if (r == 7) lat = TIMEOUT - 1;
        else if (r == 8) lat = -1;
        else             lat = int'($urandom_range(0, TIMEOUT));
        run_txn(lat, 1'b1, $urandom, g);
    endtask

    initial begin
        bit  g, exp_d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single load, memory answers in the first WAIT cycle
        d_pend = 1'b1; d_we_m = 1'b0; d_be_m = 4'hF; d_addr_m = 12'h010; d_wdata_m = '0;
        run_txn(0, 1'b0, 32'hDEADBEEF, g);

        // Store, held command, zero read data
        d_pend = 1'b1; d_we_m = 1'b1; d_be_m = 4'b0010; d_addr_m = 12'h123; d_wdata_m = 32'h0000AB00;
        run_txn(3, 1'b0, 32'h12345678, g);

        // Fetch timeout
        f_pend = 1'b1; f_addr_m = 12'h004;
        run_txn(-1, 1'b0, 32'h0, g);

        // Continuous contention
        for (int i = 0; i < 10; i++) begin
            if (!f_pend) new_fetch();
            if (!d_pend) new_data();
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (i % 2) == 0;
`else
            exp_d = (i % 5) != 4;
`endif
            run_txn(0, 1'b0, $urandom, g);
            chk("contention_owner", 64'(g), 64'(exp_d));
        end

        for (int i = 0; i < 150; i++) random_txn();

        // Reset during WAIT followed by a stale memory response
        f_pend = 1'b0; drive_reqs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_pend = 1'b1; d_we_m = 1'b0; d_be_m = 4'hF; d_addr_m = 12'h055; d_wdata_m = '0;
        drive_reqs();
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_setup_gnt", 64'(d_gnt), 64'd1);
        @(posedge clk); #1;
        d_pend = 1'b0; drive_reqs();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        starve_m = 0;
        last_data_m = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            @(negedge clk);
            chk_all_zero("rst_after");
        end
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) random_txn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single-ported unified memory between the instruction-fetch port and the load/store data port. One transaction is outstanding at a time. Each transaction is issued to memory, the block waits for the memory response, and the response is routed back to the requester that owns it. A watchdog aborts transactions the memory never answers. The block sits between the core's fetch/LSU logic and the memory array.

## Interface
Parameters:
- WIDTH, 32, data bus width
- ADDRSIZE, 12, word-address width
- TIMEOUT, 15, cycles to wait for mem_rvalid before abort (1..255)
- STARVE_MAX, 4, consecutive data grants after which a pending fetch wins (1..15)

Ports (clock and reset first):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDRSIZE  fetch word address
- if_gnt  out  1  one-cycle pulse: fetch accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  WIDTH  fetched instruction word
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables (store only)
- d_addr  in  ADDRSIZE  data word address
- d_wdata  in  WIDTH  store data
- d_gnt  out  1  one-cycle pulse: data accepted
- d_rvalid  out  1  one-cycle pulse: data transaction complete
- d_rdata  out  WIDTH  load data; 0 for stores
- err  out  1  one-cycle pulse with if_rvalid/d_rvalid: transaction timed out
- mem_req  out  1  one-cycle issue strobe to memory
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/ADDRSIZE/WIDTH  issued command, held stable from issue until completion
- mem_rvalid  in  1  memory completion (reads and writes)
- mem_rdata  in  WIDTH  read data, valid with mem_rvalid

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is sampled, select the owner, latch its command, and go to ISSUE. With no req, stay in IDLE.
- ISSUE: assert mem_req and the owner's gnt, clear the watchdog, then go to WAIT.
- WAIT: count cycles.
  - mem_rvalid: latch mem_rdata and go to RESP.
  - Count reaches TIMEOUT: latch rdata = 0, set the error flag, go to RESP.
- RESP: pulse the owner's rvalid, and pulse err if flagged. Return to IDLE.
- Selection with both requests pending: data wins. Exception: fetch wins if the starve counter equals STARVE_MAX.
- Starve counter (4 bits):
  - +1 on each data grant given while if_req is high, saturating.
  - Cleared on any fetch grant.
- mem_rvalid outside WAIT is ignored.
- A store returns d_rdata = 0.
- No sign or byte extraction is done here; that is the LSU's job.
- A requester dropping req before gnt is a protocol violation. Behaviour is undefined and is not checked.

## Timing
- Reset (rst_n low at a clock edge), all outputs: FSM to IDLE; every gnt/rvalid/err/mem_req = 0; rdata outputs = 0; mem_* command = 0; starve counter = 0; watchdog = 0.
- Reset mid-transaction: the transaction is dropped with no rvalid. A late mem_rvalid after reset is ignored.
- Request sampled at edge N → gnt and mem_req high during cycle N+1.
- mem_rvalid sampled at edge M → rvalid high during cycle M+1.
- Minimum round trip: req at N, mem_rvalid at N+2, rvalid at N+3.
- Back-to-back: a new request can be sampled at the RESP edge. Next gnt comes 2 cycles after rvalid. Peak throughput is 1 transaction per 4 cycles.
- Timeout: rvalid + err appear TIMEOUT+2 cycles after gnt. mem_rvalid arriving at the same edge the count hits TIMEOUT wins: normal completion, no err.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Fixed priority and the starve counter are replaced by a 1-bit last-owner register.
  - On contention, the port not granted last wins.
  - Last-owner resets to fetch, so the first contention goes to data.
- Undefined: fixed data-priority with the STARVE_MAX escape, as described under Operation.

## Test plan
- Single load: d_req=1, d_we=0, d_addr=0x010; memory answers 0xDEADBEEF 1 cycle after mem_req → d_gnt at N+1, d_rvalid with d_rdata=0xDEADBEEF at N+3, if_* silent.
- Contention (macro undefined): if_req and d_req held high continuously, STARVE_MAX=4 → grants D,D,D,D,F,D,D,D,D,F; with `ARB_ROUND_ROBIN_EN` → D,F,D,F.
- Store: d_we=1, d_be=4'b0010, d_wdata=0x0000AB00 → mem_we=1, mem_be=0010, mem_wdata=0x0000AB00 held until mem_rvalid; d_rvalid with d_rdata=0.
- Timeout: fetch to 0x004, mem_rvalid never asserted, TIMEOUT=15 → if_rvalid and err pulse together 17 cycles after if_gnt, if_rdata=0; next request is served normally.
- Reset mid-WAIT: rst_n low one edge during WAIT, then a stale mem_rvalid → no rvalid, all outputs 0, FSM in IDLE.
